// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: widths, register-zero constant and requester encoding shared by the write-back slice
package rf_wb_arbiter_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int REG_IDX_W = $clog2(NREG);
    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;
    typedef enum logic {REQ_ALU = 1'b0, REQ_LD = 1'b1} req_e;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: producer handshakes, decode hazard query and regfile write port
interface rf_wb_arbiter_if;
    import rf_wb_arbiter_pkg::*;
    logic                 alu_valid, alu_ready;
    logic [REG_IDX_W-1:0] alu_rd;
    logic [XLEN-1:0]      alu_data;
    logic                 ld_valid, ld_ready;
    logic [REG_IDX_W-1:0] ld_rd;
    logic [XLEN-1:0]      ld_data;
    logic                 iss_en;
    logic [REG_IDX_W-1:0] iss_rd, rs1, rs2, dec_rd;
    logic                 stall;
    logic                 wb_en;
    logic [REG_IDX_W-1:0] wb_reg;
    logic [XLEN-1:0]      wb_val;
    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
               iss_en, iss_rd, rs1, rs2, dec_rd,
        input  alu_ready, ld_ready, stall, wb_en, wb_reg, wb_val
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
               iss_en, iss_rd, rs1, rs2, dec_rd,
        output alu_ready, ld_ready, stall, wb_en, wb_reg, wb_val
    );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending-destination bit vector with set-over-clear priority and stall lookup
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_rd,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_rd,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] dec_rd,
    output logic                 stall
);
    logic [NREG-1:0] pending, pending_nxt;

    // Set is applied after clear so a newer producer of the same register stays outstanding
    always_comb begin
        pending_nxt = pending;
        if (clr_en) pending_nxt[clr_rd] = 1'b0;
        if (set_en) pending_nxt[set_rd] = 1'b1;
        pending_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) pending <= '0;
        else      pending <= pending_nxt;

    assign stall = pending[rs1] | pending[rs2] | pending[dec_rd];
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin ALU/load arbitration onto the registered regfile write port
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    rf_wb_arbiter_if.slave bus
);
    req_e                 rr_ptr;
    logic                 grant_ld, fire, wr;
    logic [REG_IDX_W-1:0] sel_rd;
    logic [XLEN-1:0]      sel_data;

    assign grant_ld      = bus.ld_valid & (~bus.alu_valid | (rr_ptr == REQ_LD));
    assign bus.alu_ready = rst & bus.alu_valid & ~grant_ld;
    assign bus.ld_ready  = rst & grant_ld;
    assign fire          = bus.alu_ready | bus.ld_ready;
    assign sel_rd        = grant_ld ? bus.ld_rd : bus.alu_rd;
    assign sel_data      = grant_ld ? bus.ld_data : bus.alu_data;
    // x0 results are consumed but never reach the regfile
    assign wr            = fire & (sel_rd != REG_ZERO);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            bus.wb_en  <= 1'b0;
            bus.wb_reg <= REG_ZERO;
            bus.wb_val <= '0;
            rr_ptr     <= REQ_ALU;
        end else begin
            bus.wb_en <= wr;
            if (wr) begin
                bus.wb_reg <= sel_rd;
                bus.wb_val <= sel_data;
            end
            if (bus.alu_valid && bus.ld_valid) rr_ptr <= grant_ld ? REQ_ALU : REQ_LD;
        end

    rf_scoreboard u_sb (
        .clk    (clk),
        .rst    (rst),
        .set_en (bus.iss_en),
        .set_rd (bus.iss_rd),
        .clr_en (bus.wb_en),
        .clr_rd (bus.wb_reg),
        .rs1    (bus.rs1),
        .rs2    (bus.rs2),
        .dec_rd (bus.dec_rd),
        .stall  (bus.stall)
    );
endmodule
